// File: rtl/led_matrix_pkg.sv
// Shared types and width helpers for the HUB75 BCM scan driver.
// Also defines where each colour channel sits inside a framebuffer word.
package led_matrix_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_BLANK,
    ST_LATCH,
    ST_SHOW
  } state_t;

  // Address width for an index range of n entries; never narrower than one bit.
  function automatic int addr_bits(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // The dwell counter covers both the longest on-time and the blanking gap.
  function automatic int on_bits(input int base_on, input int bpc, input int blank);
    int max_t;
    max_t = base_on << (bpc - 1);
    if (blank > max_t) max_t = blank;
    return $clog2(max_t + 1);
  endfunction

  // Framebuffer word is {green[BPC-1:0], red[BPC-1:0]}.
  function automatic int red_pos(input int plane);
    return plane;
  endfunction

  function automatic int green_pos(input int bpc, input int plane);
    return bpc + plane;
  endfunction

endpackage

// File: rtl/led_matrix_if.sv
// Framebuffer read port, panel pins and run control of the scan driver.
// master = scan driver, slave = framebuffer/panel side.
interface led_matrix_if
  import led_matrix_pkg::*;
#(
  parameter int COLS = 32,
  parameter int ROWS = 16,
  parameter int BPC  = 4
);
  localparam int RW = addr_bits(ROWS);
  localparam int CW = addr_bits(COLS);

  logic                 enable;
  logic                 fb_rd_en;
  logic [RW+CW-1:0]     fb_addr;
  logic [2*BPC-1:0]     fb_data;
  logic                 red;
  logic                 green;
  logic                 step;
  logic                 latch;
  logic                 output_enable;
  logic [RW-1:0]        addr;
  logic                 frame_done;

  modport master (
    input  enable, fb_data,
    output fb_rd_en, fb_addr, red, green, step, latch, output_enable, addr, frame_done
  );

  modport slave (
    output enable, fb_data,
    input  fb_rd_en, fb_addr, red, green, step, latch, output_enable, addr, frame_done
  );

endinterface

// File: rtl/led_shift_clock.sv
// Free-running 2*CLK_DIV phase counter while run is high; produces the panel
// shift clock and the strobes that pace column shifting and latch width.
module led_shift_clock #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic step,
  output logic low_start,
  output logic low_second,
  output logic low_end,
  output logic period_end
);
  localparam int PW = $clog2(2 * CLK_DIV);

  logic [PW-1:0] phase;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
    end else if (!run || phase == PW'(2 * CLK_DIV - 1)) begin
      phase <= '0;
    end else begin
      phase <= phase + 1'b1;
    end
  end

  assign step       = run && (phase >= PW'(CLK_DIV));
  assign low_start  = run && (phase == '0);
  assign low_second = run && (phase == PW'(1));
  assign low_end    = run && (phase == PW'(CLK_DIV - 1));
  assign period_end = run && (phase == PW'(2 * CLK_DIV - 1));

endmodule

// File: rtl/led_matrix_scan.sv
// HUB75 red/green scan driver with binary-coded-modulation greyscale:
// shift one bit-plane per row, blank, latch, then light it for BASE_ON << plane.
module led_matrix_scan
  import led_matrix_pkg::*;
#(
  parameter int COLS    = 32,
  parameter int ROWS    = 16,
  parameter int BPC     = 4,
  parameter int CLK_DIV = 4,
  parameter int BASE_ON = 32,
  parameter int BLANK   = 2
) (
  input  logic clk,
  input  logic rst,
  led_matrix_if.master bus
);
  localparam int RW = addr_bits(ROWS);
  localparam int CW = addr_bits(COLS);
  localparam int PW = addr_bits(BPC);
  localparam int OW = on_bits(BASE_ON, BPC, BLANK);

  state_t          state;
  state_t          state_next;
  logic [RW-1:0]   row;
  logic [RW-1:0]   addr_q;
  logic [CW-1:0]   col;
  logic [PW-1:0]   plane;
  logic [OW-1:0]   dwell;
  logic [OW-1:0]   on_time;
  logic            red_q;
  logic            green_q;
  logic            frame_done_q;

  logic            run;
  logic            step_raw;
  logic            low_start;
  logic            low_second;
  logic            low_end;
  logic            period_end;
  logic            last_col;
  logic            last_plane;
  logic            last_row;
  logic            blank_end;
  logic            show_end;
  logic            px_red;
  logic            px_green;
  logic [2*BPC-1:0] red_sh;
  logic [2*BPC-1:0] green_sh;

  assign run = (state == ST_SHIFT) || (state == ST_LATCH);

  led_shift_clock #(.CLK_DIV(CLK_DIV)) u_shift_clock (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .step      (step_raw),
    .low_start (low_start),
    .low_second(low_second),
    .low_end   (low_end),
    .period_end(period_end)
  );

  assign on_time    = OW'(BASE_ON) << plane;
  assign last_col   = (col == '0);
  assign last_plane = (plane == PW'(BPC - 1));
  assign last_row   = (row == RW'(ROWS - 1));
  assign blank_end  = (dwell == OW'(BLANK - 1));
  assign show_end   = (dwell == on_time - OW'(1));

  assign red_sh   = bus.fb_data >> red_pos(int'(plane));
  assign green_sh = bus.fb_data >> green_pos(BPC, int'(plane));
  assign px_red   = red_sh[0];
  assign px_green = green_sh[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // NOTE: every signal driven in an always_comb gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (bus.enable) state_next = ST_SHIFT;
      ST_SHIFT: if (period_end && last_col) state_next = ST_BLANK;
      ST_BLANK: if (blank_end) state_next = ST_LATCH;
      ST_LATCH: if (low_end) state_next = ST_SHOW;
      ST_SHOW:  if (show_end) state_next = (last_plane && !bus.enable) ? ST_IDLE : ST_SHIFT;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Pixel bits are forwarded straight from the read data in the second low
  // cycle so they settle CLK_DIV-1 cycles ahead of the step rise.
  always_comb begin
    bus.fb_rd_en      = 1'b0;
    bus.fb_addr       = '0;
    bus.step          = 1'b0;
    bus.latch         = 1'b0;
    bus.output_enable = 1'b0;
    bus.red           = red_q;
    bus.green         = green_q;
    case (state)
      ST_SHIFT: begin
        bus.fb_rd_en = low_start;
        bus.step     = step_raw;
        if (low_start) bus.fb_addr = {row, col};
        if (low_second) begin
          bus.red   = px_red;
          bus.green = px_green;
        end
      end
      ST_LATCH: bus.latch = 1'b1;
      ST_SHOW:  bus.output_enable = 1'b1;
      default:  ;
    endcase
  end

  assign bus.addr       = addr_q;
  assign bus.frame_done = frame_done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row          <= '0;
      plane        <= '0;
      col          <= CW'(COLS - 1);
      dwell        <= '0;
      addr_q       <= '0;
      red_q        <= 1'b0;
      green_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= (state == ST_SHOW) && show_end && last_plane && last_row;

      if (state_next != state || !(state == ST_BLANK || state == ST_SHOW)) dwell <= '0;
      else dwell <= dwell + 1'b1;

      if (state == ST_SHIFT && period_end) col <= last_col ? CW'(COLS - 1) : col - 1'b1;

      if (state == ST_SHIFT && low_second) begin
        red_q   <= px_red;
        green_q <= px_green;
      end else if (state != ST_SHIFT) begin
        red_q   <= 1'b0;
        green_q <= 1'b0;
      end

      // Row select moves only while the panel is dark.
      if (state == ST_BLANK && dwell == '0) addr_q <= row;
      else if (state == ST_IDLE)            addr_q <= '0;

      if (state == ST_SHOW && show_end) begin
        plane <= last_plane ? '0 : plane + 1'b1;
        if (last_plane) row <= last_row ? '0 : row + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Scoreboard bench: a row-level model queues expected reads, shifted bits,
// latch spacing, on-times and frame pulses; negedge monitors pop and compare.
module tb_led_matrix_scan;
  import led_matrix_pkg::*;

  localparam int COLS = 4, ROWS = 2, BPC = 2, CLK_DIV = 2, BASE_ON = 4, BLANK = 2;
  localparam int RW = addr_bits(ROWS), CW = addr_bits(COLS);
  localparam int B_COLS = 64, B_ROWS = 32, B_BPC = 4, B_CD = 2, B_ON = 32, B_BLANK = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic big_rst = 1'b1;
  always #5 clk = ~clk;

  led_matrix_if #(.COLS(COLS), .ROWS(ROWS), .BPC(BPC)) bus ();
  led_matrix_if #(.COLS(B_COLS), .ROWS(B_ROWS), .BPC(B_BPC)) big_bus ();

  led_matrix_scan #(.COLS(COLS), .ROWS(ROWS), .BPC(BPC), .CLK_DIV(CLK_DIV),
                    .BASE_ON(BASE_ON), .BLANK(BLANK)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  led_matrix_scan #(.COLS(B_COLS), .ROWS(B_ROWS), .BPC(B_BPC), .CLK_DIV(B_CD),
                    .BASE_ON(B_ON), .BLANK(B_BLANK)) big (
    .clk(clk), .rst(big_rst), .bus(big_bus));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: event with nothing expected (cycle %0d)", name, cyc);
  endtask

  // ---------------- framebuffer model ----------------
  logic [2*BPC-1:0] mem [0:ROWS*COLS-1];

  always @(posedge clk) begin
    if (bus.fb_rd_en) bus.fb_data <= mem[bus.fb_addr];
    else              bus.fb_data <= (2*BPC)'($urandom);
  end

  // ---------------- reference model ----------------
  typedef struct { int row; int on; } show_t;
  logic [RW+CW-1:0] addr_q[$];
  logic [1:0]       bit_q[$];
  int               latch_gap_q[$];
  show_t            show_q[$];
  int               fd_gap_q[$];
  int               model_row = 0;

  function automatic int plane_dur(input int p);
    return 2 * CLK_DIV * COLS + BLANK + CLK_DIV + (BASE_ON << p);
  endfunction

  function automatic int row_dur();
    int s;
    s = 0;
    for (int p = 0; p < BPC; p++) s += plane_dur(p);
    return s;
  endfunction

  // Queue everything k consecutive rows should produce, starting at model_row.
  task automatic model_rows(input int k);
    int prev_p;
    bit first_fd;
    logic [2*BPC-1:0] w;
    logic [2*BPC-1:0] sr;
    logic [2*BPC-1:0] sg;
    show_t s;
    prev_p = -1;
    first_fd = 1'b1;
    for (int i = 0; i < k; i++) begin
      for (int p = 0; p < BPC; p++) begin
        for (int c = COLS - 1; c >= 0; c--) begin
          w  = mem[model_row * COLS + c];
          sr = w >> p;
          sg = w >> (BPC + p);
          addr_q.push_back((RW+CW)'(model_row * COLS + c));
          bit_q.push_back({sr[0], sg[0]});
        end
        latch_gap_q.push_back(prev_p < 0 ? 0 : plane_dur(prev_p));
        prev_p = p;
        s.row = model_row;
        s.on  = BASE_ON << p;
        show_q.push_back(s);
      end
      if (model_row == ROWS - 1) begin
        fd_gap_q.push_back(first_fd ? 0 : ROWS * row_dur());
        first_fd = 1'b0;
      end
      model_row = (model_row + 1) % ROWS;
    end
  endtask

  // ---------------- monitors ----------------
  logic            prev_step = 0, prev_latch = 0, prev_oe = 0, prev_fd = 0;
  logic [RW-1:0]   prev_addr = '0;
  logic [1:0]      prev_rg = '0;
  int              rg_age = 0, hold_left = 0, oe_run = 0, latch_run = 0;
  int              latch_count = 0, last_latch_cyc = 0, last_fd_cyc = 0;
  show_t           cur_show;
  bit              have_show = 0;

  always @(negedge clk) begin : mon
    logic [1:0] rg;
    int gap;
    cyc++;
    rg = {bus.red, bus.green};
    if (rst) begin
      oe_run = 0; latch_run = 0; hold_left = 0; rg_age = 0; have_show = 0;
    end else begin
      if (bus.fb_rd_en) begin
        if (addr_q.size() == 0) unexpected("fb_read");
        else check("fb_addr", 64'(bus.fb_addr), 64'(addr_q.pop_front()));
      end

      if (bus.step && !prev_step) begin
        check("rg_setup", 64'(rg_age >= CLK_DIV - 1), 64'(1));
        if (bit_q.size() == 0) unexpected("step_rise");
        else check("pixel_rg", 64'(rg), 64'(bit_q.pop_front()));
        hold_left = CLK_DIV;
      end
      if (hold_left > 0) begin
        check("rg_hold", 64'(rg != prev_rg), 64'(0));
        hold_left--;
      end
      rg_age = (rg != prev_rg) ? 1 : rg_age + 1;

      if (bus.latch && !prev_latch) begin
        latch_count++;
        latch_run = 0;
        if (latch_gap_q.size() == 0) unexpected("latch");
        else begin
          gap = latch_gap_q.pop_front();
          if (gap != 0) check("plane_duration", 64'(cyc - last_latch_cyc), 64'(gap));
        end
        last_latch_cyc = cyc;
      end
      if (bus.latch) latch_run++;
      if (!bus.latch && prev_latch) check("latch_width", 64'(latch_run), 64'(CLK_DIV));

      if (bus.output_enable && !prev_oe) begin
        oe_run = 0;
        if (show_q.size() == 0) unexpected("show");
        else begin
          cur_show = show_q.pop_front();
          have_show = 1;
          check("show_row", 64'(bus.addr), 64'(cur_show.row));
        end
      end
      if (bus.output_enable) oe_run++;
      if (!bus.output_enable && prev_oe && have_show) begin
        check("on_time", 64'(oe_run), 64'(cur_show.on));
        have_show = 0;
      end

      check("latch_oe_overlap", 64'(bus.latch && bus.output_enable), 64'(0));
      if (bus.addr != prev_addr) check("addr_change_lit", 64'(prev_oe || bus.output_enable), 64'(0));

      if (bus.frame_done) begin
        check("frame_done_width", 64'(prev_fd), 64'(0));
        if (fd_gap_q.size() == 0) unexpected("frame_done");
        else begin
          gap = fd_gap_q.pop_front();
          if (gap != 0) check("frame_period", 64'(cyc - last_fd_cyc), 64'(gap));
        end
        last_fd_cyc = cyc;
      end
    end
    prev_step = bus.step; prev_latch = bus.latch; prev_oe = bus.output_enable;
    prev_fd = bus.frame_done; prev_addr = bus.addr; prev_rg = rg;
  end

  // Large-panel instance: on-times cycle 32..256 and the row select wraps 31 -> 0.
  logic        big_prev_oe = 0;
  int          big_run = 0, big_row = 0, big_plane = 0;
  bit          big_wrapped = 0, big_done = 0;

  always @(negedge clk) begin : big_mon
    if (!big_rst) begin
      if (big_bus.output_enable && !big_prev_oe) begin
        big_run = 0;
        check("big_show_row", 64'(big_bus.addr), 64'(big_row));
        if (big_wrapped && !big_done) big_done = 1;
      end
      if (big_bus.output_enable) big_run++;
      if (!big_bus.output_enable && big_prev_oe) begin
        check("big_on_time", 64'(big_run), 64'(B_ON << big_plane));
        big_plane++;
        if (big_plane == B_BPC) begin
          big_plane = 0;
          if (big_row == B_ROWS - 1) big_wrapped = 1;
          big_row = (big_row + 1) % B_ROWS;
        end
      end
    end
    big_prev_oe = big_bus.output_enable;
  end

  // ---------------- stimulus ----------------
  task automatic check_idle(input string name);
    check(name, 64'({bus.fb_rd_en, bus.red, bus.green, bus.step, bus.latch,
                     bus.output_enable, bus.frame_done, bus.addr, bus.fb_addr}), 64'(0));
  endtask

  task automatic wait_latches(input int target);
    int n;
    n = 0;
    while (latch_count < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (latch_count < target) unexpected("latch_timeout");
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((addr_q.size() + bit_q.size() + latch_gap_q.size() + show_q.size() + fd_gap_q.size()) != 0
           && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if ((addr_q.size() + bit_q.size() + latch_gap_q.size() + show_q.size() + fd_gap_q.size()) != 0)
      unexpected("drain_timeout");
    repeat ((BASE_ON << (BPC - 1)) + 8) @(negedge clk);
  endtask

  // Scan k rows, dropping enable somewhere inside plane 0 of the last one.
  task automatic run_rows(input int k);
    int target;
    model_rows(k);
    target = latch_count + (k - 1) * BPC + 1;
    bus.enable = 1'b1;
    wait_latches(target);
    repeat ($urandom_range(0, CLK_DIV + BASE_ON - 2)) @(negedge clk);
    bus.enable = 1'b0;
    drain();
    check_idle("idle_after_run");
  endtask

  task automatic fill_random();
    for (int i = 0; i < ROWS * COLS; i++) mem[i] = (2*BPC)'($urandom);
  endtask

  initial begin : big_stim
    big_bus.enable  = 1'b0;
    big_bus.fb_data = '0;
    repeat (3) @(negedge clk);
    big_rst = 1'b0;
    big_bus.enable = 1'b1;
  end

  initial begin : main
    int n;
    logic [1:0] c2;
    bus.enable = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        c2 = 2'(c);
        mem[r * COLS + c] = (2*BPC)'({~c2, c2});
      end

    repeat (3) @(negedge clk);
    check_idle("reset_state");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("idle_after_release");

    run_rows(2 * ROWS);   // two back-to-back frames, column-pattern pixels
    fill_random();
    run_rows(3);          // ends mid-frame on row 0
    run_rows(1);          // enable dropped in row 1, plane 0
    fill_random();
    run_rows(ROWS);

    // Asynchronous reset while a plane is lit.
    fill_random();
    model_rows(2);
    bus.enable = 1'b1;
    n = 0;
    while (!bus.output_enable && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!bus.output_enable) unexpected("show_timeout");
    #2 rst = 1'b1;
    #1;
    check("rst_async_oe", 64'(bus.output_enable), 64'(0));
    check("rst_async_latch", 64'(bus.latch), 64'(0));
    check("rst_async_step", 64'(bus.step), 64'(0));
    bus.enable = 1'b0;
    @(negedge clk);
    addr_q.delete(); bit_q.delete(); latch_gap_q.delete(); show_q.delete(); fd_gap_q.delete();
    model_row = 0;
    @(negedge clk);
    check_idle("reset_mid_frame");
    rst = 1'b0;
    @(negedge clk);
    run_rows(2);

    n = 0;
    while (!big_done && n < 60000) begin
      @(negedge clk);
      n++;
    end
    check("big_addr_wrap", 64'(big_done), 64'(1));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/led_matrix_scan.md
# led_matrix_scan

Parametrised scan driver for HUB75-style red/green LED matrix panels with binary-coded-modulation (BCM) greyscale. It reads pixels from an external framebuffer through a synchronous read port and shifts one bit-plane per row into the panel. It then latches the plane and lights it for a time weighted by plane significance. It sits between the framebuffer RAM and the panel connector pins.

## Interface
Parameters:
- COLS, 32, columns shifted per row (≥2)
- ROWS, 16, multiplexed scan rows; RW = clog2(ROWS) address bits
- BPC, 4, bits per colour channel (number of BCM planes)
- CLK_DIV, 4, clk cycles per half-period of `step` (≥2)
- BASE_ON, 32, clk cycles `output_enable` is high for plane 0
- BLANK, 2, clk cycles of forced-dark dead time before each latch (≥1)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  run scanning; sampled only in IDLE and at row end
- fb_rd_en  out  1  framebuffer read strobe
- fb_addr  out  RW+CW  {row, col} read address, CW = clog2(COLS)
- fb_data  in  2*BPC  {green[BPC-1:0], red[BPC-1:0]}, valid 1 cycle after fb_rd_en
- red, green  out  1  serial pixel data to panel
- step  out  1  panel shift clock; panel samples on rising edge
- latch  out  1  panel latch, active high
- output_enable  out  1  1 = LEDs lit (pin inversion handled at top level)
- addr  out  RW  displayed row
- frame_done  out  1  one-cycle pulse after last plane of last row

## Operation
- Async reset: all outputs 0, state IDLE, row = 0, plane = 0.
- States: IDLE → SHIFT → BLANK → LATCH → SHOW → (SHIFT | IDLE).
- IDLE: outputs 0. Moves to SHIFT on the first cycle with enable = 1.
- SHIFT: columns are sent in order COLS-1 down to 0. Each column takes 2*CLK_DIV cycles.
  - Low phase (step = 0, CLK_DIV cycles): fb_rd_en = 1 on cycle 0. red/green are updated on cycle 1 to fb_data[plane] and fb_data[BPC+plane].
  - High phase (step = 1, CLK_DIV cycles): red/green are held.
  - output_enable = 0 throughout SHIFT, so the previous plane is not shown during shifting.
- BLANK: BLANK cycles, output_enable = 0, step = 0. addr loads the current row on the first BLANK cycle. addr changes only while output_enable = 0.
- LATCH: CLK_DIV cycles with latch = 1.
- SHOW: output_enable = 1 for BASE_ON << plane cycles.
- After SHOW, the plane increments. When plane wraps past BPC-1:
  - the row increments;
  - enable is sampled: 0 → IDLE, 1 → SHIFT.
- When the row wraps past ROWS-1: frame_done = 1 on the first cycle of the next state, then row = 0.
- The on-time counter is wide enough for BASE_ON << (BPC-1) with no overflow.
- Deasserting enable mid-row: the current row completes all planes, then the block enters IDLE. A frame is never cut mid-plane.

## Timing
- Read latency of fb_data is exactly 1 cycle. fb_addr is stable during the cycle fb_rd_en = 1.
- Plane p duration: 2*CLK_DIV*COLS + BLANK + CLK_DIV + (BASE_ON << p) cycles.
- Row duration: sum of the plane durations over p = 0..BPC-1.
- Frame duration: ROWS × row duration.
- red/green are stable for at least CLK_DIV-1 cycles before each rising edge of step and CLK_DIV cycles after it.
- latch and output_enable are never high in the same cycle.
- Reset mid-frame: outputs drop to 0 asynchronously. After reset release, scanning restarts from row 0, plane 0, column COLS-1.

## Structure
- Package led_matrix_pkg holds:
  - the state enum (IDLE, SHIFT, BLANK, LATCH, SHOW);
  - width helper constants/functions (RW, CW, on-time counter width);
  - the fb_data field layout (red and green slice positions).
- Sub-module led_shift_clock generates step plus its low/high phase strobes from CLK_DIV and is reused by the SHIFT and LATCH timing. Everything else (FSM, row/plane/column counters) lives in led_matrix_scan.

## Test plan
Default test parameters: COLS=4, ROWS=2, BPC=2, CLK_DIV=2, BASE_ON=4, BLANK=2.
- **Frame timing:** enable = 1 held; plane durations 24 and 28 cycles → frame_done pulses every 104 cycles, each pulse 1 cycle wide.
- **Pixel data:** fb model returns red = col[1:0], green = ~col[1:0].
  - Plane 0: bits sampled on step rises are red 1,0,1,0 and green 0,1,0,1 (columns 3..0).
  - Plane 1: red 1,1,0,0.
  - Checks: the fb_addr sequence is {r,3},{r,2},{r,1},{r,0}, and fb_data is used exactly 1 cycle after each read.
- **BCM weighting and overlap:** output_enable high for 4 cycles after each plane 0 latch and 8 after each plane 1 latch. latch & output_enable are never both 1. addr changes only while output_enable = 0.
- **Enable drop:** enable → 0 mid-plane-0 of row 1 → plane 1 of row 1 completes, frame_done pulses, block enters IDLE with all outputs 0. Re-enable → next shift starts at row 0.
- **Async reset:** rst asserted during SHOW → output_enable, latch and step go 0 before the next clk edge. After release, the first fb_addr is {0,3}.
- **Scaling:** COLS=64, ROWS=32, BPC=4 → addr wraps 31→0 and the plane 3 on-time is 256 cycles (BASE_ON=32).
